// File: rtl/hex_capture_pkg.sv
// Shared constants, FSM state and record type for the seven-segment display capture block.
package hex_capture_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned HEX_W  = DIGITS * SEG_W;
  localparam int unsigned VAL_W  = DIGITS * NIB_W;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    SETTLE = 1'b0,
    STABLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [VAL_W-1:0]  value;
    logic [DIGITS-1:0] illegal;
    logic [DIGITS-1:0] blank;
  } rec_t;

endpackage

// File: rtl/hex_capture_if.sv
// Display inputs and record stream of hex_capture; out_blank exists only with HEX_CAPTURE_BLANK_EN.
interface hex_capture_if;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] out_value;
  logic [5:0]  out_illegal;
  logic        overrun;
`ifdef HEX_CAPTURE_BLANK_EN
  logic [5:0]  out_blank;

  modport master (output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, out_ready,
                  input  out_valid, out_value, out_illegal, overrun, out_blank);
  modport slave  (input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, out_ready,
                  output out_valid, out_value, out_illegal, overrun, out_blank);
`else
  modport master (output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, out_ready,
                  input  out_valid, out_value, out_illegal, overrun);
  modport slave  (input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, out_ready,
                  output out_valid, out_value, out_illegal, overrun);
`endif
endinterface

// File: rtl/hex_capture_seg7_to_nibble.sv
// Combinational seven-segment pattern to nibble decoder; HEX_CAPTURE_BLANK_EN makes 7F a legal blank.
module seg7_to_nibble
  import hex_capture_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [NIB_W-1:0] nibble_o,
  output logic             illegal_o,
  output logic             blank_o
);

  always_comb begin
    nibble_o  = '0;
    illegal_o = 1'b0;
    blank_o   = 1'b0;
    case (seg_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
`ifdef HEX_CAPTURE_BLANK_EN
      SEG_BLANK: blank_o = 1'b1;
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_capture.sv
// Debounces the six display digits, decodes them and emits each new stable value on a valid/ready stream.
// Optional feature macro: HEX_CAPTURE_BLANK_EN (legal blank digit plus out_blank flags).
module hex_capture
  import hex_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic          clock,
  input  logic          reset,
  hex_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STABLE_CYCLES);

  logic [HEX_W-1:0]  hex_in;
  logic [HEX_W-1:0]  s_q, s_d;
  logic [CNT_W-1:0]  c_q, c_d;
  state_e            state_q, state_d;
  rec_t              rec_q, rec_d, rec_new;
  logic              last_vld_q, last_vld_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              commit, accept;
  logic [VAL_W-1:0]  dec_value;
  logic [DIGITS-1:0] dec_illegal;
  logic [DIGITS-1:0] dec_blank;

  assign hex_in = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

  // Decode the sampled vector; at commit it equals the live inputs.
  for (genvar d = 0; d < int'(DIGITS); d++) begin : g_dec
    seg7_to_nibble u_dec (
      .seg_i     (s_q[d*SEG_W +: SEG_W]),
      .nibble_o  (dec_value[d*NIB_W +: NIB_W]),
      .illegal_o (dec_illegal[d]),
      .blank_o   (dec_blank[d])
    );
  end

  assign rec_new = '{value: dec_value, illegal: dec_illegal, blank: dec_blank};

  // rec_q doubles as the last committed record: a commit either loads it or matches it.
  always_comb begin
    s_d        = s_q;
    c_d        = c_q;
    state_d    = state_q;
    rec_d      = rec_q;
    last_vld_d = last_vld_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    accept     = valid_q && bus.out_ready;
    commit     = 1'b0;

    if (hex_in != s_q) begin
      s_d = hex_in;
      c_d = '0;
    end else if (c_q != C_MAX) begin
      c_d = c_q + CNT_W'(1);
    end

    state_d = (c_d == C_MAX) ? STABLE : SETTLE;
    commit  = (state_q == SETTLE) && (state_d == STABLE);

    if (accept) valid_d = 1'b0;

    if (commit) begin
      last_vld_d = 1'b1;
      if (!last_vld_q || (rec_new != rec_q)) begin
        rec_d   = rec_new;
        valid_d = 1'b1;
        if (valid_q && !bus.out_ready) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s_q        <= '1;
      c_q        <= '0;
      state_q    <= SETTLE;
      rec_q      <= '0;
      last_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      s_q        <= s_d;
      c_q        <= c_d;
      state_q    <= state_d;
      rec_q      <= rec_d;
      last_vld_q <= last_vld_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_value   = rec_q.value;
  assign bus.out_illegal = rec_q.illegal;
  assign bus.overrun     = overrun_q;
`ifdef HEX_CAPTURE_BLANK_EN
  assign bus.out_blank   = rec_q.blank;
`endif

endmodule

// File: tb/tb_hex_capture.sv
// Directed self-checking bench for hex_capture with STABLE_CYCLES = 4.
module tb_hex_capture;

  localparam int unsigned STABLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  hex_capture_if bus ();

  hex_capture #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(8)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hex(input logic [6:0] h5, h4, h3, h2, h1, h0);
    bus.HEX5 = h5; bus.HEX4 = h4; bus.HEX3 = h3;
    bus.HEX2 = h2; bus.HEX1 = h1; bus.HEX0 = h0;
  endtask

  // Ticks until out_valid is seen or the budget runs out.
  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    set_hex(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tick(); tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_value !== 24'h0 || bus.out_illegal !== 6'h0 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%b val=%h ill=%h ovr=%b want 0/000000/00/0",
               bus.out_valid, bus.out_value, bus.out_illegal, bus.overrun);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL blank_early: out_valid=%b after edge 3, want 0", bus.out_valid);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h0 || bus.out_illegal !== 6'h3F) begin
      fails++;
      $display("FAIL blank_commit: got v=%b val=%h ill=%h want 1/000000/3f",
               bus.out_valid, bus.out_value, bus.out_illegal);
    end
    bus.out_ready = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL blank_accept: out_valid=%b after accept, want 0", bus.out_valid);
    end
  endtask

  task automatic test_value();
    int cnt = 0;
    int first = -1;
    logic [23:0] val = '0;
    logic [5:0]  ill = '1;
    bus.out_ready = 1'b1;
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h30);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin first = i; val = bus.out_value; ill = bus.out_illegal; end
      end
    end
    tests++;
    if (cnt != 1 || first != 4) begin
      fails++; $display("FAIL value_latency: records=%0d first_edge=%0d want 1/4", cnt, first);
    end
    tests++;
    if (val !== 24'h000023 || ill !== 6'h00) begin
      fails++; $display("FAIL value_data: val=%h ill=%h want 000023/00", val, ill);
    end
  endtask

  task automatic test_glitch();
    int cnt = 0;
    logic [23:0] val = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, ((i / 2) % 2 == 1) ? 7'h79 : 7'h40);
      tick();
      if (bus.out_valid === 1'b1) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++; $display("FAIL glitch_quiet: records=%0d during toggling, want 0", cnt);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin cnt++; val = bus.out_value; end
    end
    tests++;
    if (cnt != 1 || val !== 24'h000001) begin
      fails++; $display("FAIL glitch_hold: records=%0d val=%h want 1/000001", cnt, val);
    end
  endtask

  task automatic test_same_value();
    int cnt = 0;
    bit seen;
    bus.out_ready = 1'b1;
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h30);
    wait_valid(8, seen);
    tests++;
    if (!seen || bus.out_value !== 24'h000023) begin
      fails++; $display("FAIL same_first: seen=%0d val=%h want 1/000023", seen, bus.out_value);
    end
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h19);
    tick();
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h30);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++; $display("FAIL same_repeat: records=%0d, want 0", cnt);
    end
  endtask

  task automatic test_decode();
    bit seen;
    bus.out_ready = 1'b1;
    set_hex(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08);
    wait_valid(8, seen);
    tests++;
    if (!seen || bus.out_value !== 24'hFEDCBA || bus.out_illegal !== 6'h00) begin
      fails++; $display("FAIL decode_af: seen=%0d val=%h ill=%h want 1/fedcba/00", seen, bus.out_value, bus.out_illegal);
    end
    set_hex(7'h19, 7'h30, 7'h79, 7'h10, 7'h00, 7'h02);
    wait_valid(8, seen);
    tests++;
    if (!seen || bus.out_value !== 24'h431986 || bus.out_illegal !== 6'h00) begin
      fails++; $display("FAIL decode_mix: seen=%0d val=%h ill=%h want 1/431986/00", seen, bus.out_value, bus.out_illegal);
    end
    set_hex(7'h12, 7'h78, 7'h24, 7'h7F, 7'h79, 7'h55);
    wait_valid(8, seen);
    tests++;
    if (!seen || bus.out_value !== 24'h572010 || bus.out_illegal !== 6'h05) begin
      fails++; $display("FAIL decode_illegal: seen=%0d val=%h ill=%h want 1/572010/05", seen, bus.out_value, bus.out_illegal);
    end
    tick();
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12);
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h000005 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_first: v=%b val=%h ovr=%b want 1/000005/0", bus.out_valid, bus.out_value, bus.overrun);
    end
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78);
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h000007 || bus.overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_replace: v=%b val=%h ovr=%b want 1/000007/1", bus.out_valid, bus.out_value, bus.overrun);
    end
    bus.out_ready = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_sticky: v=%b ovr=%b want 0/1", bus.out_valid, bus.overrun);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.out_value !== 24'h0) begin
      fails++; $display("FAIL overrun_reset: v=%b ovr=%b val=%h want 0/0/000000", bus.out_valid, bus.overrun, bus.out_value);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_early: out_valid=%b 4 edges after reset, want 0", bus.out_valid);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h000007) begin
      fails++; $display("FAIL b2b_first: v=%b val=%h want 1/000007", bus.out_valid, bus.out_value);
    end
    set_hex(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79);
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h000007) begin
      fails++; $display("FAIL b2b_hold: v=%b val=%h want 1/000007", bus.out_valid, bus.out_value);
    end
    bus.out_ready = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_value !== 24'h000001 || bus.overrun !== 1'b0) begin
      fails++; $display("FAIL b2b_same_edge: v=%b val=%h ovr=%b want 1/000001/0", bus.out_valid, bus.out_value, bus.overrun);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

`ifdef HEX_CAPTURE_BLANK_EN
  task automatic test_blank();
    bit seen;
    bus.out_ready = 1'b1;
    set_hex(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    wait_valid(8, seen);
    tests++;
    if (!seen || bus.out_value !== 24'h000000 || bus.out_illegal !== 6'h00 || bus.out_blank !== 6'h20) begin
      fails++; $display("FAIL blank_digit: seen=%0d val=%h ill=%h blank=%h want 1/000000/00/20",
                        seen, bus.out_value, bus.out_illegal, bus.out_blank);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_value();
    test_glitch();
    test_same_value();
    test_decode();
    test_overrun();
    test_back_to_back();
`ifdef HEX_CAPTURE_BLANK_EN
    test_blank();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
